gpio_bank: RTL

- Parametrised GPIO register bank on the CPU peripheral bus: debounced inputs, byte-writable outputs, per-bit rising/falling edge capture, and a maskable level interrupt.
- Replaces fixed-width switch/button/LED registers. Channel widths, debounce timing and input reset level are set per instance.
- One clk_100M domain. Bus, filters and interrupt all run on the same clock.

---
 rtl/gpio_bank_pkg.sv | 33 +++
 rtl/gpio_bank_if.sv | 21 ++
 rtl/gpio_debounce.sv | 55 +++++
 rtl/gpio_bank.sv | 116 +++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// gpio_bank shared definitions.
// Register offsets, CTRL bit index and byte-lane helpers.
package gpio_bank_pkg;

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_RISE_EN = 3'd3;
  localparam logic [2:0] REG_FALL_EN = 3'd4;
  localparam logic [2:0] REG_CTRL    = 3'd5;

  localparam int CTRL_IE = 0;

  function automatic logic [31:0] byte_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    for (int k = 0; k < 4; k++)
      m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] m;
    m = byte_mask(be);
    return (old & ~m) | (wd & m);
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// gpio_bank peripheral bus.
// CPU side drives master, the bank is the slave.
interface gpio_bank_if;

  logic        en;
  logic [2:0]  addr;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (
    output en, addr, we, din,
    input  dout
  );

  modport slave (
    input  en, addr, we, din,
    output dout
  );

endinterface

// File: rtl/gpio_debounce.sv
// One input channel: 2-flop synchroniser,
// tick-counted debounce and edge pulses.
module gpio_debounce #(
  parameter int   DEB_CNT = 4,
  parameter logic IN_INIT = 1'b0
) (
  input  logic clk_100M,
  input  logic rst,
  input  logic in_raw,
  input  logic tick,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  logic       s1;
  logic       sync;
  logic [3:0] cnt;
  logic       accept;

  // Pulses fire on the edge where stable takes the new level.
  assign accept = tick && (sync != stable)
                  && (cnt == 4'(DEB_CNT - 1));
  assign rise_pulse = accept & sync;
  assign fall_pulse = accept & ~sync;

  // Bring the raw pin into the clk_100M domain.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      s1   <= IN_INIT;
      sync <= IN_INIT;
    end else begin
      s1   <= in_raw;
      sync <= s1;
    end
  end

  // Accept a new level after DEB_CNT mismatching ticks.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      cnt    <= '0;
      stable <= IN_INIT;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/gpio_bank.sv
// GPIO register bank: debounced inputs, byte-writable
// outputs, edge capture and a maskable level interrupt.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int   IN_WIDTH  = 16,
  parameter int   OUT_WIDTH = 16,
  parameter int   TICK_DIV  = 65536,
  parameter int   DEB_CNT   = 4,
  parameter logic IN_INIT   = 1'b0
) (
  input  logic                 clk_100M,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_raw,
  output logic [OUT_WIDTH-1:0] out_pins,
  gpio_bank_if.slave           bus,
  output logic                 irq
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0]        pre;
  logic                 tick;
  logic [IN_WIDTH-1:0]  stable;
  logic [IN_WIDTH-1:0]  rise_p;
  logic [IN_WIDTH-1:0]  fall_p;
  logic [OUT_WIDTH-1:0] out_q;
  logic [IN_WIDTH-1:0]  status;
  logic [IN_WIDTH-1:0]  rise_en;
  logic [IN_WIDTH-1:0]  fall_en;
  logic                 ctrl_ie;
  logic [IN_WIDTH-1:0]  edge_set;
  logic [IN_WIDTH-1:0]  w1c;
  logic [31:0]          rdata;
  logic [31:0]          dout_q;

  assign tick     = (pre == PW'(TICK_DIV - 1));
  assign out_pins = out_q;
  assign bus.dout = dout_q;
  assign edge_set = (rise_p & rise_en) | (fall_p & fall_en);
  assign w1c      = (bus.en && bus.addr == REG_STATUS)
                    ? IN_WIDTH'(bus.din & byte_mask(bus.we))
                    : '0;

  // Shared debounce sample tick.
  always_ff @(posedge clk_100M) begin
    if (rst || tick)
      pre <= '0;
    else
      pre <= pre + PW'(1);
  end

  for (genvar g = 0; g < IN_WIDTH; g++) begin : g_ch
    gpio_debounce #(
      .DEB_CNT (DEB_CNT),
      .IN_INIT (IN_INIT)
    ) u_deb (
      .clk_100M   (clk_100M),
      .rst        (rst),
      .in_raw     (in_raw[g]),
      .tick       (tick),
      .stable     (stable[g]),
      .rise_pulse (rise_p[g]),
      .fall_pulse (fall_p[g])
    );
  end

  // Read mux; unmapped offsets read 0.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (bus.addr == REG_IN):      rdata = 32'(stable);
      (bus.addr == REG_OUT):     rdata = 32'(out_q);
      (bus.addr == REG_STATUS):  rdata = 32'(status);
      (bus.addr == REG_RISE_EN): rdata = 32'(rise_en);
      (bus.addr == REG_FALL_EN): rdata = 32'(fall_en);
      (bus.addr == REG_CTRL):    rdata = 32'(ctrl_ie);
      default:                   rdata = '0;
    endcase
  end

  // Registered read data, held while idle.
  always_ff @(posedge clk_100M) begin
    if (rst)
      dout_q <= '0;
    else if (bus.en)
      dout_q <= rdata;
  end

  // R/W registers, edge capture (set beats clear) and irq.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      out_q   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      ctrl_ie <= 1'b0;
      status  <= '0;
      irq     <= 1'b0;
    end else begin
      if (bus.en && bus.addr == REG_OUT)
        out_q <= OUT_WIDTH'(byte_merge(
                   32'(out_q), bus.din, bus.we));
      if (bus.en && bus.addr == REG_RISE_EN)
        rise_en <= IN_WIDTH'(byte_merge(
                     32'(rise_en), bus.din, bus.we));
      if (bus.en && bus.addr == REG_FALL_EN)
        fall_en <= IN_WIDTH'(byte_merge(
                     32'(fall_en), bus.din, bus.we));
      if (bus.en && bus.addr == REG_CTRL && bus.we[0])
        ctrl_ie <= bus.din[CTRL_IE];
      status <= (status & ~w1c) | edge_set;
      irq    <= ctrl_ie & (|status);
    end
  end

endmodule
